// File: rtl/wb_bank_slave.sv
// Pipelined Wishbone bank responder: word-wide RAM behind a fixed-latency response pipe,
// with periodic refresh windows that stall the bus.
module wb_bank_slave #(
  parameter int AW             = 32,
  parameter int MW             = 64,
  parameter int BW             = MW / 8,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int LATENCY        = 2,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [MW-1:0] i_wb_data,
  input  logic [BW-1:0] i_wb_be,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic          o_wb_err,
  output logic [MW-1:0] o_wb_data,
  output logic [1:0]    o_dbg_state
);
  localparam int BW_LOG2 = $clog2(BW);
  localparam logic [AW:0]   LIMIT     = (AW+1)'(BW) << MEM_WORDS_LOG2;
  localparam logic [31:0]   PERIOD_M1 = 32'(REFRESH_PERIOD - 1);
  localparam logic [31:0]   RCYC_M1   = 32'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {SERVE = 2'd0, DRAIN = 2'd1, REFRESH = 2'd2} state_t;

  state_t              state, state_nx;
  logic [31:0]         rcnt, rcnt_nx;
  logic [LATENCY-1:0]  pv, perr;
  logic [MW-1:0]       pdata [LATENCY];
  logic [MW-1:0]       mem [1 << MEM_WORDS_LOG2];
  logic                accept, bad;
  logic [MEM_WORDS_LOG2-1:0] widx;

  // Handshake: a request transfers on any rising edge where cyc && stb && !stall;
  // stall depends only on FSM state, so a master may hold stb and simply wait.
  assign o_wb_stall  = (state != SERVE);
  assign accept      = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign widx        = i_wb_addr[BW_LOG2 +: MEM_WORDS_LOG2];
  assign bad         = (i_wb_addr[BW_LOG2-1:0] != '0) || ({1'b0, i_wb_addr} >= LIMIT);
  assign o_dbg_state = state;

  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    case (state)
      SERVE: begin
        if (REFRESH_PERIOD != 0 && rcnt == PERIOD_M1) begin
          state_nx = DRAIN;
          rcnt_nx  = '0;
        end else begin
          rcnt_nx = rcnt + 32'd1;
        end
      end
      DRAIN: begin
        if (pv == '0) state_nx = REFRESH;
      end
      REFRESH: begin
        if (rcnt == RCYC_M1) begin
          state_nx = SERVE;
          rcnt_nx  = '0;
        end else begin
          rcnt_nx = rcnt + 32'd1;
        end
      end
      default: begin
        state_nx = SERVE;
        rcnt_nx  = '0;
      end
    endcase
  end

  // Dropping cyc aborts everything in flight; already-committed writes remain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= SERVE;
      rcnt  <= '0;
      pv    <= '0;
      perr  <= '0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      if (!i_wb_cyc) begin
        pv <= '0;
      end else begin
        pv[0]    <= accept;
        perr[0]  <= bad;
        pdata[0] <= (accept && !bad && !i_wb_we) ? mem[widx] : '0;
        for (int i = 1; i < LATENCY; i++) begin
          pv[i]    <= pv[i-1];
          perr[i]  <= perr[i-1];
          pdata[i] <= pdata[i-1];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && accept && !bad && i_wb_we) begin
      for (int k = 0; k < BW; k++) begin
        if (i_wb_be[k]) mem[widx][8*k +: 8] <= i_wb_data[8*k +: 8];
      end
    end
  end

  assign o_wb_ack  = pv[LATENCY-1] && !perr[LATENCY-1];
  assign o_wb_err  = pv[LATENCY-1] && perr[LATENCY-1];
  assign o_wb_data = o_wb_ack ? pdata[LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_bank_slave.sv
// Scoreboarded bench for wb_bank_slave: reference RAM model, response order/latency,
// error decode, refresh window length, abort and reset behaviour.
module tb_wb_bank_slave;
  localparam int LAT = 2;
  localparam int RP  = 16;
  localparam int RC  = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [31:0] i_wb_addr = '0;
  logic [63:0] i_wb_data = '0;
  logic [7:0]  i_wb_be = '0;
  logic        o_wb_ack, o_wb_stall, o_wb_err;
  logic [63:0] o_wb_data;
  logic [1:0]  o_dbg_state;

  wb_bank_slave #(.LATENCY(LAT), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_be(i_wb_be),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_err(o_wb_err),
    .o_wb_data(o_wb_data), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc_cnt = 0;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // scoreboard state: {err, data} and the edge count at which each request is accepted
  logic [64:0] exp_q[$];
  int          acc_q[$];
  logic [63:0] mdl [int];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge before the edge that accepts the request.
  task automatic push_exp(input logic we, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] be);
    int          idx;
    logic [63:0] w;
    idx = int'(addr >> 3);
    if (addr[2:0] != 3'b0 || addr >= 32'h8000) begin
      exp_q.push_back({1'b1, 64'h0});
    end else if (we) begin
      w = mdl.exists(idx) ? mdl[idx] : 64'h0;
      for (int k = 0; k < 8; k++) if (be[k]) w[8*k +: 8] = data[8*k +: 8];
      mdl[idx] = w;
      exp_q.push_back({1'b0, 64'h0});
    end else begin
      exp_q.push_back({1'b0, mdl[idx]});
    end
    acc_q.push_back(cyc_cnt + 1);
  endtask

  // Responses due at or after edge r are killed by an abort/reset applied at edge r.
  task automatic drop_after(input int r);
    while (acc_q.size() > 0 && acc_q[$] + LAT - 1 >= r) begin
      void'(acc_q.pop_back());
      void'(exp_q.pop_back());
    end
  endtask

  // driver tasks: entered and left at a negedge
  task automatic req(input logic we, input logic [31:0] addr, input logic [63:0] data,
                     input logic [7:0] be);
    int n = 0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = addr; i_wb_data = data; i_wb_be = be;
    while (o_wb_stall && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) check("stall_timeout", 1, 0);
    else push_exp(we, addr, data, be);
    @(negedge i_clk);
    i_wb_stb = 1'b0;
  endtask

  task automatic wait_refresh_end();
    int n = 0;
    while (!o_wb_stall && n < 64) begin @(negedge i_clk); n++; end
    while (o_wb_stall && n < 128) begin @(negedge i_clk); n++; end
    if (n >= 128) check("refresh_timeout", 1, 0);
  endtask

  // response monitor
  always @(negedge i_clk) begin
    logic [64:0] e;
    int          a;
    if (mon_en) begin
      check("ack_err_excl", o_wb_ack && o_wb_err, 0);
      if (!o_wb_ack) check("data_idle", o_wb_data, 0);
      if (o_wb_ack || o_wb_err) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp", {o_wb_err, o_wb_data}, e);
          check("rsp_latency", cyc_cnt - a, LAT - 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          serve_run, high_run, phase, n;
    logic [31:0] addr;

    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    i_wb_cyc = 1'b1;
    check("rst_ack", o_wb_ack, 0);
    check("rst_err", o_wb_err, 0);
    check("rst_data", o_wb_data, 0);
    check("rst_stall", o_wb_stall, 0);
    mon_en = 1'b1;

    // write then read back-to-back
    req(1'b1, 32'h10, 64'h1122334455667788, 8'hFF);
    req(1'b0, 32'h10, 64'h0, 8'h00);

    // partial write
    req(1'b1, 32'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    req(1'b1, 32'h08, 64'h0, 8'h0F);
    req(1'b0, 32'h08, 64'h0, 8'h00);

    // fill a region for later reads, plus word 0 and the last word
    req(1'b1, 32'h0, 64'hA5A5_0000_5A5A_FFFF, 8'hFF);
    req(1'b1, 32'h7FF8, {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 16; i++) req(1'b1, 32'h100 + 32'(8*i), {$urandom, $urandom}, 8'hFF);

    // be=0 write leaves the word alone
    req(1'b1, 32'h100, {$urandom, $urandom}, 8'h00);
    req(1'b0, 32'h100, 64'h0, 8'h00);

    // errors: misaligned, first out-of-range, bad writes must not touch RAM
    req(1'b0, 32'h04, 64'h0, 8'h00);
    req(1'b0, 32'h8000, 64'h0, 8'h00);
    req(1'b1, 32'h8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    req(1'b1, 32'h14, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    req(1'b0, 32'h0, 64'h0, 8'h00);
    req(1'b0, 32'h10, 64'h0, 8'h00);
    req(1'b0, 32'h7FF8, 64'h0, 8'h00);

    // back-to-back reads right after a refresh window
    wait_refresh_end();
    for (int i = 0; i < 8; i++) begin
      check("pipe_stall", o_wb_stall, 0);
      req(1'b0, 32'h100 + 32'(8 * $urandom_range(0, 15)), 64'h0, 8'h00);
    end

    // continuous requests through one full serve/drain/refresh cycle
    wait_refresh_end();
    serve_run = 0; high_run = 0; phase = 0; n = 0;
    while (phase < 2 && n < 100) begin
      addr = 32'h100 + 32'(8 * $urandom_range(0, 15));
      i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = addr;
      if (!o_wb_stall) begin
        push_exp(1'b0, addr, 64'h0, 8'h00);
        if (phase == 1) phase = 2;
        else serve_run++;
      end else begin
        phase = 1;
        high_run++;
      end
      @(negedge i_clk);
      n++;
    end
    i_wb_stb = 1'b0;
    check("serve_len", serve_run, RP);
    check("stall_len", high_run, LAT + 1 + RC);

    // abort: drop cyc after two reads
    repeat (4) @(negedge i_clk);
    req(1'b0, 32'h108, 64'h0, 8'h00);
    req(1'b0, 32'h110, 64'h0, 8'h00);
    i_wb_cyc = 1'b0;
    drop_after(cyc_cnt + 1);
    @(negedge i_clk);
    i_wb_cyc = 1'b1;
    repeat (6) @(negedge i_clk);

    // reset with responses in flight
    req(1'b0, 32'h118, 64'h0, 8'h00);
    req(1'b0, 32'h120, 64'h0, 8'h00);
    i_reset = 1'b1;
    drop_after(cyc_cnt + 1);
    @(negedge i_clk);
    i_reset = 1'b0;
    check("mid_rst_ack", o_wb_ack, 0);
    check("mid_rst_err", o_wb_err, 0);
    check("mid_rst_data", o_wb_data, 0);

    // written data survives the reset
    req(1'b0, 32'h10, 64'h0, 8'h00);
    req(1'b0, 32'h08, 64'h0, 8'h00);

    repeat (12) @(negedge i_clk);
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
